issue_unit: RTL and testbench
=============================

Name: issue_unit

Overview:
- Producer end of the reservation-station and load/store-buffer issue interfaces.
- Pops one instruction per cycle from the instruction queue and decodes RV32I into the internal 6-bit opcode and immediate.
- Resolves rs1/rs2 through its own register-status table (value, busy, ROB tag), with ROB and ALU/LSB broadcast bypass.
- Issues one registered entry per cycle to ROB and to either RS (ALU ops) or LSB (loads/stores).

Parameters:
- ROB_W, 6, ROB index width; the 0 tag is legal.
- NREG, 32, architectural register count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  misprediction flush
- iq_valid  in  1  instruction queue head valid
- iq_inst  in  32  head instruction
- iq_pc  in  32  head pc
- iq_pop  out  1  combinational; head consumed this cycle
- rob_full  in  1  ROB cannot accept
- rob_tail  in  6  ROB index the next issued entry receives
- rs_full  in  1  RS full (asserted with one free slot left)
- lsb_full  in  1  LSB full (same early-full rule)
- rob_q1_idx, rob_q2_idx  out  6  combinational ROB lookup of rs1/rs2 tags
- rob_q1_ready, rob_q2_ready  in  1  looked-up entry has its result
- rob_q1_val, rob_q2_val  in  32  looked-up result
- commit_valid  in  1  ROB commit writes a register
- commit_rd  in  5; commit_val  in  32; commit_rob_index  in  6
- alu_valid, alu_is_load  in  1; alu_res  in  32; alu_rob_index_out  in  6  ALU broadcast
- lsb_valid  in  1; lsb_rs_res  in  32; lsb_rs_rob_index_out  in  6  LSB broadcast
- rob_issue_valid, rs_issue_valid, lsb_issue_valid  out  1  registered issue strobes
- issue_opcode  out  6
- issue_val1, issue_val2  out  32
- issue_dep1, issue_dep2  out  6
- issue_has_dep1, issue_has_dep2  out  1
- issue_rob_index  out  6
- issue_imm, issue_pc  out  32
- issue_rd  out  5

Behaviour:
- Reset (async, rst_n low): every output and table entry 0, all busy bits clear.
- Decode (combinational):
  - Opcode map: LUI=1, AUIPC=2, JAL=3, JALR=4, BEQ..BGEU=5..10, LB,LH,LW,LBU,LHU=11..15, SB,SH,SW=16..18, ADDI..SRAI=19..27, ADD..AND=28..37; 0=illegal.
  - Immediates are sign-extended per I/S/B/U/J format. Shift-immediates carry shamt in imm[4:0].
  - rd is 0 for branches and stores. rs2 is used only by R-type, branch and store.
- Issue condition: go = rdy & ~flush & iq_valid & ~rob_full & (is_mem ? ~lsb_full : ~rs_full). iq_pop = go.
- Illegal opcode: popped and dropped; no strobes.
- On go (registered, visible next cycle):
  - rob_issue_valid=1, plus rs_issue_valid or lsb_issue_valid.
  - issue_rob_index=rob_tail.
  - If rd≠0: busy[rd]=1, tag[rd]=rob_tail.
- Strobes are single-cycle and drop to 0 in any cycle without go.
- Operand resolution, per source, in priority order:
  1. rs=x0 or unused: val 0, no dep.
  2. Register not busy: reg_val.
  3. Busy, and commit_valid & commit_rob_index==tag: commit_val.
  4. rob_qN_ready: rob_qN_val.
  5. alu_valid & ~alu_is_load & alu_rob_index_out==tag: alu_res.
  6. lsb_valid & lsb_rs_rob_index_out==tag: lsb_rs_res.
  7. Otherwise: has_dep=1, dep=tag, val=0.
- Commit:
  - Always writes reg_val[commit_rd] (rd≠0).
  - Clears busy only if tag[commit_rd]==commit_rob_index.
  - A same-cycle issue renaming the same rd wins: busy stays 1 with the new tag.
- Same-instruction rd==rs: operands resolve against pre-issue table state.
- Flush (rdy high): clear all busy bits and all strobes; reg_val kept; no pop that cycle. A commit in the flush cycle still writes reg_val.
- x0: never busy, value constant 0.

Decomposition:
- Package riscv_defs: opcode constants, ROB_W, RV32I major-opcode/funct constants.
- Sub-module inst_decoder (pure combinational): inst → opcode, rd, rs1, rs2, imm, uses_rs2, is_mem.
- Register-status table and issue register stay in issue_unit.

Test Plan:
- Reset, then ADDI x1,x0,5 at pc 0x100, rob_tail=3 → next cycle rs_issue_valid=1, opcode=19, val1=0, has_dep1=0, imm=5, issue_rob_index=3; busy[1]=1, tag[1]=3.
- ADD x2,x1,x1 next with ROB not ready and no broadcast → has_dep1=has_dep2=1, dep1=dep2=3. Repeat with alu_valid, alu_rob_index_out=3, alu_res=7 in the issue cycle → val1=val2=7, no deps.
- LW x3,8(x1) with lsb_full=1 → iq_pop=0, no strobes. Drop lsb_full → lsb_issue_valid=1, opcode=13, imm=8.
- Commit rd=1, rob_index=3, val=5 in the same cycle ADDI x1 issues with rob_tail=9 → reg_val[1]=5, busy[1]=1, tag[1]=9.
- Busy table with flush=1 and iq_valid=1 → no pop, all strobes 0. Next ADD x2,x1,x1 → val1=val2=reg_val[1], no deps.
- Assert rst_n low mid-stream asynchronously → all outputs 0 immediately. rdy=0 with iq_valid → no pop, state frozen.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared RV32I encodings, internal opcode numbering and issue payload types.
package riscv_defs;

  localparam int unsigned ROB_W = 6;
  localparam int unsigned NREG  = 32;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;
  localparam int unsigned REG_W = 5;

  typedef logic [OPC_W-1:0] opc_t;

  // Internal opcode numbering; 0 marks an instruction that is dropped.
  localparam opc_t OP_ILLEGAL = 6'd0;
  localparam opc_t OP_LUI     = 6'd1;
  localparam opc_t OP_AUIPC   = 6'd2;
  localparam opc_t OP_JAL     = 6'd3;
  localparam opc_t OP_JALR    = 6'd4;
  localparam opc_t OP_BEQ     = 6'd5;
  localparam opc_t OP_BNE     = 6'd6;
  localparam opc_t OP_BLT     = 6'd7;
  localparam opc_t OP_BGE     = 6'd8;
  localparam opc_t OP_BLTU    = 6'd9;
  localparam opc_t OP_BGEU    = 6'd10;
  localparam opc_t OP_LB      = 6'd11;
  localparam opc_t OP_LH      = 6'd12;
  localparam opc_t OP_LW      = 6'd13;
  localparam opc_t OP_LBU     = 6'd14;
  localparam opc_t OP_LHU     = 6'd15;
  localparam opc_t OP_SB      = 6'd16;
  localparam opc_t OP_SH      = 6'd17;
  localparam opc_t OP_SW      = 6'd18;
  localparam opc_t OP_ADDI    = 6'd19;
  localparam opc_t OP_SLTI    = 6'd20;
  localparam opc_t OP_SLTIU   = 6'd21;
  localparam opc_t OP_XORI    = 6'd22;
  localparam opc_t OP_ORI     = 6'd23;
  localparam opc_t OP_ANDI    = 6'd24;
  localparam opc_t OP_SLLI    = 6'd25;
  localparam opc_t OP_SRLI    = 6'd26;
  localparam opc_t OP_SRAI    = 6'd27;
  localparam opc_t OP_ADD     = 6'd28;
  localparam opc_t OP_SUB     = 6'd29;
  localparam opc_t OP_SLL     = 6'd30;
  localparam opc_t OP_SLT     = 6'd31;
  localparam opc_t OP_SLTU    = 6'd32;
  localparam opc_t OP_XOR     = 6'd33;
  localparam opc_t OP_SRL     = 6'd34;
  localparam opc_t OP_SRA     = 6'd35;
  localparam opc_t OP_OR      = 6'd36;
  localparam opc_t OP_AND     = 6'd37;

  // RV32I major opcodes
  localparam logic [6:0] MAJ_LUI    = 7'b0110111;
  localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
  localparam logic [6:0] MAJ_JAL    = 7'b1101111;
  localparam logic [6:0] MAJ_JALR   = 7'b1100111;
  localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
  localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
  localparam logic [6:0] MAJ_STORE  = 7'b0100011;
  localparam logic [6:0] MAJ_OPIMM  = 7'b0010011;
  localparam logic [6:0] MAJ_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic             has_dep;
    logic [ROB_W-1:0] dep;
  } operand_t;

  typedef struct packed {
    opc_t             opcode;
    logic [XLEN-1:0]  val1;
    logic [XLEN-1:0]  val2;
    logic [ROB_W-1:0] dep1;
    logic [ROB_W-1:0] dep2;
    logic             has_dep1;
    logic             has_dep2;
    logic [ROB_W-1:0] rob_index;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rd;
  } issue_pkt_t;

endpackage

// File: rtl/inst_decoder.sv
// Pure combinational RV32I decoder: internal opcode, register fields, immediate,
// plus whether rs2 is read and whether the op goes to the load/store buffer.
module inst_decoder
  import riscv_defs::*;
(
  input  logic [31:0]      inst,
  output opc_t             opcode,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [XLEN-1:0]  imm,
  output logic             uses_rs2,
  output logic             is_mem
);

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  always_comb begin
    opcode   = OP_ILLEGAL;
    rd       = inst[11:7];
    rs1      = inst[19:15];
    rs2      = inst[24:20];
    imm      = '0;
    uses_rs2 = 1'b0;
    is_mem   = 1'b0;
    case (inst[6:0])
      MAJ_LUI: begin
        opcode = OP_LUI;
        rs1    = '0;
        imm    = imm_u;
      end
      MAJ_AUIPC: begin
        opcode = OP_AUIPC;
        rs1    = '0;
        imm    = imm_u;
      end
      MAJ_JAL: begin
        opcode = OP_JAL;
        rs1    = '0;
        imm    = imm_j;
      end
      MAJ_JALR: begin
        if (funct3 == 3'b000) opcode = OP_JALR;
        imm = imm_i;
      end
      MAJ_BRANCH: begin
        case (funct3)
          3'b000:  opcode = OP_BEQ;
          3'b001:  opcode = OP_BNE;
          3'b100:  opcode = OP_BLT;
          3'b101:  opcode = OP_BGE;
          3'b110:  opcode = OP_BLTU;
          3'b111:  opcode = OP_BGEU;
          default: opcode = OP_ILLEGAL;
        endcase
        rd       = '0;
        imm      = imm_b;
        uses_rs2 = 1'b1;
      end
      MAJ_LOAD: begin
        case (funct3)
          3'b000:  opcode = OP_LB;
          3'b001:  opcode = OP_LH;
          3'b010:  opcode = OP_LW;
          3'b100:  opcode = OP_LBU;
          3'b101:  opcode = OP_LHU;
          default: opcode = OP_ILLEGAL;
        endcase
        imm    = imm_i;
        is_mem = 1'b1;
      end
      MAJ_STORE: begin
        case (funct3)
          3'b000:  opcode = OP_SB;
          3'b001:  opcode = OP_SH;
          3'b010:  opcode = OP_SW;
          default: opcode = OP_ILLEGAL;
        endcase
        rd       = '0;
        imm      = imm_s;
        uses_rs2 = 1'b1;
        is_mem   = 1'b1;
      end
      MAJ_OPIMM: begin
        imm = imm_i;
        case (funct3)
          3'b000: opcode = OP_ADDI;
          3'b010: opcode = OP_SLTI;
          3'b011: opcode = OP_SLTIU;
          3'b100: opcode = OP_XORI;
          3'b110: opcode = OP_ORI;
          3'b111: opcode = OP_ANDI;
          3'b001: begin
            imm = imm_sh;
            if (funct7 == F7_ZERO) opcode = OP_SLLI;
          end
          default: begin
            imm = imm_sh;
            if (funct7 == F7_ZERO)     opcode = OP_SRLI;
            else if (funct7 == F7_ALT) opcode = OP_SRAI;
          end
        endcase
      end
      MAJ_OP: begin
        uses_rs2 = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_ZERO)     opcode = OP_ADD;
            else if (funct7 == F7_ALT) opcode = OP_SUB;
          end
          3'b001: if (funct7 == F7_ZERO) opcode = OP_SLL;
          3'b010: if (funct7 == F7_ZERO) opcode = OP_SLT;
          3'b011: if (funct7 == F7_ZERO) opcode = OP_SLTU;
          3'b100: if (funct7 == F7_ZERO) opcode = OP_XOR;
          3'b101: begin
            if (funct7 == F7_ZERO)     opcode = OP_SRL;
            else if (funct7 == F7_ALT) opcode = OP_SRA;
          end
          3'b110: if (funct7 == F7_ZERO) opcode = OP_OR;
          default: if (funct7 == F7_ZERO) opcode = OP_AND;
        endcase
      end
      default: opcode = OP_ILLEGAL;
    endcase
    // Dropped instructions must never rename or look anything up.
    if (opcode == OP_ILLEGAL) begin
      rd       = '0;
      rs1      = '0;
      uses_rs2 = 1'b0;
      is_mem   = 1'b0;
    end
  end

endmodule

// File: rtl/issue_unit.sv
// Decodes the instruction-queue head, renames through the register-status table
// and issues one registered entry per cycle to the ROB and to the RS or LSB.
module issue_unit
  import riscv_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             flush,
  input  logic             iq_valid,
  input  logic [31:0]      iq_inst,
  input  logic [31:0]      iq_pc,
  output logic             iq_pop,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_tail,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic [ROB_W-1:0] rob_q1_idx,
  output logic [ROB_W-1:0] rob_q2_idx,
  input  logic             rob_q1_ready,
  input  logic             rob_q2_ready,
  input  logic [31:0]      rob_q1_val,
  input  logic [31:0]      rob_q2_val,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [31:0]      commit_val,
  input  logic [ROB_W-1:0] commit_rob_index,
  input  logic             alu_valid,
  input  logic             alu_is_load,
  input  logic [31:0]      alu_res,
  input  logic [ROB_W-1:0] alu_rob_index_out,
  input  logic             lsb_valid,
  input  logic [31:0]      lsb_rs_res,
  input  logic [ROB_W-1:0] lsb_rs_rob_index_out,
  output logic             rob_issue_valid,
  output logic             rs_issue_valid,
  output logic             lsb_issue_valid,
  output logic [5:0]       issue_opcode,
  output logic [31:0]      issue_val1,
  output logic [31:0]      issue_val2,
  output logic [ROB_W-1:0] issue_dep1,
  output logic [ROB_W-1:0] issue_dep2,
  output logic             issue_has_dep1,
  output logic             issue_has_dep2,
  output logic [ROB_W-1:0] issue_rob_index,
  output logic [31:0]      issue_imm,
  output logic [31:0]      issue_pc,
  output logic [4:0]       issue_rd
);

  logic [XLEN-1:0]  reg_val [NREG];
  logic [ROB_W-1:0] rob_tag [NREG];
  logic [NREG-1:0]  busy;

  opc_t             dec_opcode;
  logic [REG_W-1:0] dec_rd, dec_rs1, dec_rs2, rs2_eff;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_uses_rs2, dec_is_mem;
  logic             go, legal, do_issue;
  operand_t         op1, op2;
  issue_pkt_t       issue_q;

  inst_decoder u_dec (
    .inst     (iq_inst),
    .opcode   (dec_opcode),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .imm      (dec_imm),
    .uses_rs2 (dec_uses_rs2),
    .is_mem   (dec_is_mem)
  );

  assign go       = rdy & ~flush & iq_valid & ~rob_full & (dec_is_mem ? ~lsb_full : ~rs_full);
  assign legal    = (dec_opcode != OP_ILLEGAL);
  assign do_issue = go & legal;
  assign iq_pop   = go;

  assign rs2_eff    = dec_uses_rs2 ? dec_rs2 : '0;
  assign rob_q1_idx = rob_tag[dec_rs1];
  assign rob_q2_idx = rob_tag[rs2_eff];

  // Source lookup against the pre-issue table, newest result source first after the file.
  function automatic operand_t resolve(input logic [REG_W-1:0] rs, input logic is_busy,
                                       input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] rv,
                                       input logic q_ready, input logic [XLEN-1:0] q_val);
    operand_t r;
    r = '0;
    if (rs == '0) begin
      r.val = '0;
    end else if (!is_busy) begin
      r.val = rv;
    end else if (commit_valid && commit_rob_index == tag) begin
      r.val = commit_val;
    end else if (q_ready) begin
      r.val = q_val;
    end else if (alu_valid && !alu_is_load && alu_rob_index_out == tag) begin
      r.val = alu_res;
    end else if (lsb_valid && lsb_rs_rob_index_out == tag) begin
      r.val = lsb_rs_res;
    end else begin
      r.has_dep = 1'b1;
      r.dep     = tag;
    end
    return r;
  endfunction

  always_comb begin
    op1 = resolve(dec_rs1, busy[dec_rs1], rob_tag[dec_rs1], reg_val[dec_rs1],
                  rob_q1_ready, rob_q1_val);
    op2 = resolve(rs2_eff, busy[rs2_eff], rob_tag[rs2_eff], reg_val[rs2_eff],
                  rob_q2_ready, rob_q2_val);
  end

  // Register-status table and issue register; later assignments take priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        reg_val[i] <= '0;
        rob_tag[i] <= '0;
      end
      busy            <= '0;
      rob_issue_valid <= 1'b0;
      rs_issue_valid  <= 1'b0;
      lsb_issue_valid <= 1'b0;
      issue_q         <= '0;
    end else if (rdy) begin
      rob_issue_valid <= do_issue;
      rs_issue_valid  <= do_issue & ~dec_is_mem;
      lsb_issue_valid <= do_issue & dec_is_mem;
      if (do_issue) begin
        issue_q.opcode    <= dec_opcode;
        issue_q.val1      <= op1.val;
        issue_q.val2      <= op2.val;
        issue_q.dep1      <= op1.dep;
        issue_q.dep2      <= op2.dep;
        issue_q.has_dep1  <= op1.has_dep;
        issue_q.has_dep2  <= op2.has_dep;
        issue_q.rob_index <= rob_tail;
        issue_q.imm       <= dec_imm;
        issue_q.pc        <= iq_pc;
        issue_q.rd        <= dec_rd;
      end
      if (commit_valid && commit_rd != '0) begin
        reg_val[commit_rd] <= commit_val;
        if (rob_tag[commit_rd] == commit_rob_index) busy[commit_rd] <= 1'b0;
      end
      if (do_issue && dec_rd != '0) begin
        busy[dec_rd]    <= 1'b1;
        rob_tag[dec_rd] <= rob_tail;
      end
      if (flush) busy <= '0;
    end
  end

  assign issue_opcode    = issue_q.opcode;
  assign issue_val1      = issue_q.val1;
  assign issue_val2      = issue_q.val2;
  assign issue_dep1      = issue_q.dep1;
  assign issue_dep2      = issue_q.dep2;
  assign issue_has_dep1  = issue_q.has_dep1;
  assign issue_has_dep2  = issue_q.has_dep2;
  assign issue_rob_index = issue_q.rob_index;
  assign issue_imm       = issue_q.imm;
  assign issue_pc        = issue_q.pc;
  assign issue_rd        = issue_q.rd;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: expected issue entries are queued as each
// instruction is presented and compared once the registered outputs appear.
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, iq_valid, iq_pop;
  logic [31:0] iq_inst, iq_pc;
  logic        rob_full, rs_full, lsb_full;
  logic [5:0]  rob_tail, rob_q1_idx, rob_q2_idx;
  logic        rob_q1_ready, rob_q2_ready;
  logic [31:0] rob_q1_val, rob_q2_val;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [5:0]  commit_rob_index;
  logic        alu_valid, alu_is_load;
  logic [31:0] alu_res;
  logic [5:0]  alu_rob_index_out;
  logic        lsb_valid;
  logic [31:0] lsb_rs_res;
  logic [5:0]  lsb_rs_rob_index_out;
  logic        rob_issue_valid, rs_issue_valid, lsb_issue_valid;
  logic [5:0]  issue_opcode, issue_dep1, issue_dep2, issue_rob_index;
  logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
  logic        issue_has_dep1, issue_has_dep2;
  logic [4:0]  issue_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rob_v, rs_v, lsb_v;
    logic [31:0] opc, v1, h1, d1, v2, h2, d2, imm, pc, rd, idx;
  } exp_t;

  exp_t sb[$];

  issue_unit dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pop(iq_pop),
    .rob_full(rob_full), .rob_tail(rob_tail), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_q1_idx(rob_q1_idx), .rob_q2_idx(rob_q2_idx),
    .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
    .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_index(commit_rob_index),
    .alu_valid(alu_valid), .alu_is_load(alu_is_load), .alu_res(alu_res),
    .alu_rob_index_out(alu_rob_index_out),
    .lsb_valid(lsb_valid), .lsb_rs_res(lsb_rs_res), .lsb_rs_rob_index_out(lsb_rs_rob_index_out),
    .rob_issue_valid(rob_issue_valid), .rs_issue_valid(rs_issue_valid),
    .lsb_issue_valid(lsb_issue_valid), .issue_opcode(issue_opcode),
    .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_dep1(issue_dep1), .issue_dep2(issue_dep2),
    .issue_has_dep1(issue_has_dep1), .issue_has_dep2(issue_has_dep2),
    .issue_rob_index(issue_rob_index), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rd(issue_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic exp_t none();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // kind: 0 = RS-bound, 1 = LSB-bound
  function automatic exp_t mk(input int opc, input bit kind,
                              input logic [31:0] v1, input int h1, input int d1,
                              input logic [31:0] v2, input int h2, input int d2,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input int rd, input int idx);
    exp_t e;
    e.rob_v = 1'b1; e.rs_v = !kind; e.lsb_v = kind;
    e.opc = 32'(opc); e.v1 = v1; e.h1 = 32'(h1); e.d1 = 32'(d1);
    e.v2 = v2; e.h2 = 32'(h2); e.d2 = 32'(d2);
    e.imm = imm; e.pc = pc; e.rd = 32'(rd); e.idx = 32'(idx);
    return e;
  endfunction

  task automatic present(input logic [31:0] inst, input logic [31:0] pc, input int tail);
    @(negedge clk);
    iq_valid = 1'b1; iq_inst = inst; iq_pc = pc; rob_tail = 6'(tail);
    #1;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("rob_issue_valid", 32'(rob_issue_valid), 32'(e.rob_v));
    check("rs_issue_valid", 32'(rs_issue_valid), 32'(e.rs_v));
    check("lsb_issue_valid", 32'(lsb_issue_valid), 32'(e.lsb_v));
    if (e.rob_v) begin
      check("opcode", 32'(issue_opcode), e.opc);
      check("val1", issue_val1, e.v1);
      check("has_dep1", 32'(issue_has_dep1), e.h1);
      check("dep1", 32'(issue_dep1), e.d1);
      check("val2", issue_val2, e.v2);
      check("has_dep2", 32'(issue_has_dep2), e.h2);
      check("dep2", 32'(issue_dep2), e.d2);
      check("imm", issue_imm, e.imm);
      check("pc", issue_pc, e.pc);
      check("rd", 32'(issue_rd), e.rd);
      check("rob_index", 32'(issue_rob_index), e.idx);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input int tail,
                       input logic exp_pop, input exp_t e);
    present(inst, pc, tail);
    check("iq_pop", 32'(iq_pop), 32'(exp_pop));
    sb.push_back(e);
    tick();
  endtask

  task automatic drive_q(input logic [31:0] inst, input logic [31:0] pc, input int tail,
                         input int q1, input int q2, input exp_t e);
    present(inst, pc, tail);
    check("rob_q1_idx", 32'(rob_q1_idx), 32'(q1));
    check("rob_q2_idx", 32'(rob_q2_idx), 32'(q2));
    check("iq_pop", 32'(iq_pop), 32'd1);
    sb.push_back(e);
    tick();
  endtask

  task automatic idle();
    @(negedge clk);
    iq_valid = 1'b0;
    #1;
    check("iq_pop_idle", 32'(iq_pop), 32'd0);
    sb.push_back(none());
    tick();
  endtask

  logic [31:0] add211;
  initial add211 = enc_r(5'd2, 5'd1, 5'd1);

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; iq_valid = 1'b0; iq_inst = '0; iq_pc = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail = '0;
    rob_q1_ready = 1'b0; rob_q2_ready = 1'b0; rob_q1_val = '0; rob_q2_val = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_val = '0; commit_rob_index = '0;
    alu_valid = 1'b0; alu_is_load = 1'b0; alu_res = '0; alu_rob_index_out = '0;
    lsb_valid = 1'b0; lsb_rs_res = '0; lsb_rs_rob_index_out = '0;
    #12;
    check("rst_rob_v", 32'(rob_issue_valid), 32'd0);
    check("rst_rs_v", 32'(rs_issue_valid), 32'd0);
    check("rst_lsb_v", 32'(lsb_issue_valid), 32'd0);
    check("rst_opcode", 32'(issue_opcode), 32'd0);
    check("rst_val1", issue_val1, 32'd0);
    check("rst_pop", 32'(iq_pop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,5 then dependent ADDs with and without ALU bypass
    drive(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5), 32'h100, 3, 1'b1,
          mk(19, 0, 0, 0, 0, 0, 0, 0, 32'd5, 32'h100, 1, 3));
    drive_q(add211, 32'h104, 4, 3, 3, mk(28, 0, 0, 1, 3, 0, 1, 3, 0, 32'h104, 2, 4));
    alu_valid = 1'b1; alu_rob_index_out = 6'd3; alu_res = 32'd7;
    drive(add211, 32'h108, 5, 1'b1, mk(28, 0, 32'd7, 0, 0, 32'd7, 0, 0, 0, 32'h108, 2, 5));
    alu_valid = 1'b0;

    // LW x3,8(x1) stalled on early-full LSB, then issued
    lsb_full = 1'b1;
    drive(enc_i(7'h03, 3'd2, 5'd3, 5'd1, 12'd8), 32'h10c, 6, 1'b0, none());
    lsb_full = 1'b0;
    drive(enc_i(7'h03, 3'd2, 5'd3, 5'd1, 12'd8), 32'h10c, 6, 1'b1,
          mk(13, 1, 0, 1, 3, 0, 0, 0, 32'd8, 32'h10c, 3, 6));
    drive(enc_s(3'd2, 5'd3, 5'd1, 12'd4), 32'h110, 7, 1'b1,
          mk(18, 1, 0, 1, 3, 0, 1, 6, 32'd4, 32'h110, 0, 7));

    // Commit bypass into issue, then commit racing a rename of the same rd
    commit_valid = 1'b1; commit_rd = 5'd3; commit_rob_index = 6'd6; commit_val = 32'h33;
    drive(enc_r(5'd4, 5'd3, 5'd0), 32'h114, 8, 1'b1,
          mk(28, 0, 32'h33, 0, 0, 0, 0, 0, 0, 32'h114, 4, 8));
    commit_rd = 5'd1; commit_rob_index = 6'd3; commit_val = 32'd5;
    drive(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5), 32'h118, 9, 1'b1,
          mk(19, 0, 0, 0, 0, 0, 0, 0, 32'd5, 32'h118, 1, 9));
    commit_valid = 1'b0;
    drive_q(add211, 32'h11c, 10, 9, 9, mk(28, 0, 0, 1, 9, 0, 1, 9, 0, 32'h11c, 2, 10));
    rob_q1_ready = 1'b1; rob_q1_val = 32'h55;
    drive(add211, 32'h120, 11, 1'b1, mk(28, 0, 32'h55, 0, 0, 0, 1, 9, 0, 32'h120, 2, 11));
    rob_q1_ready = 1'b0;

    // Stale-tag commit writes the value but leaves x1 busy
    commit_valid = 1'b1; commit_rd = 5'd1; commit_rob_index = 6'd3; commit_val = 32'h63;
    idle();
    commit_valid = 1'b0;
    drive(add211, 32'h124, 12, 1'b1, mk(28, 0, 0, 1, 9, 0, 1, 9, 0, 32'h124, 2, 12));

    // Flush: no pop, no strobes, busy cleared, values kept
    flush = 1'b1;
    drive(add211, 32'h128, 13, 1'b0, none());
    flush = 1'b0;
    drive(add211, 32'h128, 13, 1'b1, mk(28, 0, 32'h63, 0, 0, 32'h63, 0, 0, 0, 32'h128, 2, 13));

    // Illegal is popped and dropped; branch and LUI decode
    drive(32'h0, 32'h12c, 14, 1'b1, none());
    drive(enc_b(3'd0, 5'd0, 5'd0, 13'h1ff8), 32'h200, 14, 1'b1,
          mk(5, 0, 0, 0, 0, 0, 0, 0, 32'hfffffff8, 32'h200, 0, 14));
    drive({20'h12345, 5'd7, 7'h37}, 32'h204, 15, 1'b1,
          mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h12345000, 32'h204, 7, 15));

    // ALU load broadcast is ignored; LSB broadcast is taken
    alu_valid = 1'b1; alu_is_load = 1'b1; alu_rob_index_out = 6'd15; alu_res = 32'h66;
    drive_q(enc_r(5'd8, 5'd7, 5'd0), 32'h208, 16, 15, 0,
            mk(28, 0, 0, 1, 15, 0, 0, 0, 0, 32'h208, 8, 16));
    alu_valid = 1'b0; alu_is_load = 1'b0;
    lsb_valid = 1'b1; lsb_rs_rob_index_out = 6'd15; lsb_rs_res = 32'h77;
    drive(enc_r(5'd9, 5'd7, 5'd0), 32'h20c, 17, 1'b1,
          mk(28, 0, 32'h77, 0, 0, 0, 0, 0, 0, 32'h20c, 9, 17));
    lsb_valid = 1'b0;

    // rdy low: nothing popped, no rename of x5
    idle();
    rdy = 1'b0;
    drive(enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'd5), 32'h210, 20, 1'b0, none());
    rdy = 1'b1;
    drive(enc_r(5'd6, 5'd5, 5'd5), 32'h214, 21, 1'b1,
          mk(28, 0, 0, 0, 0, 0, 0, 0, 0, 32'h214, 6, 21));

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rob_v", 32'(rob_issue_valid), 32'd0);
    check("arst_rs_v", 32'(rs_issue_valid), 32'd0);
    check("arst_opcode", 32'(issue_opcode), 32'd0);
    check("arst_rob_index", 32'(issue_rob_index), 32'd0);
    check("arst_pc", issue_pc, 32'd0);
    check("arst_rd", 32'(issue_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(add211, 32'h218, 22, 1'b1, mk(28, 0, 0, 0, 0, 0, 0, 0, 0, 32'h218, 2, 22));
    idle();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
